// File: rtl/lab2_pkg.sv
// lab2_pkg: shared constants and FSM state type for the 8-slot TDM demultiplexer.
package lab2_pkg;
    localparam int SLOT_W  = 3;
    localparam int N_SLOTS = 2 ** SLOT_W;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;
endpackage

// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if: serial TDM input side and frame output side of the demultiplexer.
interface tdm_demux8_if;
    import lab2_pkg::*;
    logic                 g_n;
    logic                 valid_i;
    logic                 frame_start;
    logic                 din;
    logic [SLOT_W-1:0]    sel;
    logic [N_SLOTS-1:0]   y_n;
    logic [N_SLOTS-1:0]   dout;
    logic                 frame_valid;
    logic                 sync_err;
    logic [7:0]           frame_cnt;

    modport master (
        output g_n, valid_i, frame_start, din,
        input  sel, y_n, dout, frame_valid, sync_err, frame_cnt
    );

    modport slave (
        input  g_n, valid_i, frame_start, din,
        output sel, y_n, dout, frame_valid, sync_err, frame_cnt
    );
endinterface

// File: rtl/ls138.sv
// ls138: 3-to-8 active-low decoder with a single active-high enable.
module ls138 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       enable,
    output logic [7:0] y_n
);
    logic [7:0] hot;

    always_comb begin
        hot = 8'h01 << {c, b, a};
        y_n = enable ? ~hot : 8'hFF;
    end
endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: collects 8 strobed serial slots into a parallel frame, aligned by frame_start.
module tdm_demux8 #(
    parameter int SLOT_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux8_if.slave   bus
);
    import lab2_pkg::state_e;
    import lab2_pkg::IDLE;
    import lab2_pkg::RECV;

    localparam int NS = 2 ** SLOT_W;
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NS - 1);

    state_e            state_q;
    logic [SLOT_W-1:0] sel_q;
    logic [NS-1:0]     shift_q;
    logic [NS-1:0]     dout_q;
    logic              frame_valid_q;
    logic              sync_err_q;
    logic [7:0]        frame_cnt_q;
    logic              accept;
    logic [NS-1:0]     first_bit;

    assign accept    = bus.valid_i && !bus.g_n;
    assign first_bit = {{(NS-1){1'b0}}, bus.din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            shift_q       <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (bus.frame_start) begin
                            shift_q <= first_bit;
                            sel_q   <= SLOT_W'(1);
                            state_q <= RECV;
                        end
                    end
                    RECV: begin
                        // A new frame_start mid-frame realigns on this bit as slot 0.
                        if (bus.frame_start) begin
                            sync_err_q <= 1'b1;
                            shift_q    <= first_bit;
                            sel_q      <= SLOT_W'(1);
                        end else if (sel_q == LAST) begin
                            dout_q        <= {bus.din, shift_q[NS-2:0]};
                            frame_valid_q <= 1'b1;
                            frame_cnt_q   <= frame_cnt_q + 8'd1;
                            sel_q         <= '0;
                            state_q       <= IDLE;
                        end else begin
                            shift_q[sel_q] <= bus.din;
                            sel_q          <= sel_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    ls138 u_dec (
        .a      (sel_q[0]),
        .b      (sel_q[1]),
        .c      (sel_q[2]),
        .enable (state_q == RECV && !bus.g_n),
        .y_n    (bus.y_n)
    );

    assign bus.sel         = sel_q;
    assign bus.dout        = dout_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: randomized and directed stimulus with a queue-based frame scoreboard.
module tb_tdm_demux8;
    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux8_if dif();
    tdm_demux8 #(.SLOT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int sync_seen = 0;
    int exp_sync = 0;
    int fv_cyc[$];
    exp_t exp_q[$];
    bit in_frame = 0;
    bit bits[$];
    logic [7:0] m_cnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: a frame is the list of bits seen since the last accepted frame_start.
    function automatic void model(bit fs, bit d);
        if (fs) begin
            if (in_frame) exp_sync++;
            bits.delete();
            bits.push_back(d);
            in_frame = 1;
        end else if (in_frame) begin
            bits.push_back(d);
            if (bits.size() == 8) begin
                logic [7:0] v;
                v = 8'd0;
                for (int i = 0; i < 8; i++) v[i] = bits[i];
                m_cnt = m_cnt + 8'd1;
                exp_q.push_back('{v, m_cnt});
                in_frame = 0;
                bits.delete();
            end
        end
    endfunction

    task automatic drive(bit v, bit fs, bit d, bit gn);
        int es;
        logic [7:0] ey;
        dif.valid_i = v;
        dif.frame_start = fs;
        dif.din = d;
        dif.g_n = gn;
        @(posedge clk);
        if (v && !gn) model(fs, d);
        #1;
        es = in_frame ? bits.size() : 0;
        ey = 8'h01 << es;
        ey = (in_frame && !gn) ? ~ey : 8'hFF;
        chk("sel", 32'(dif.sel), 32'(es));
        chk("y_n", 32'(dif.y_n), 32'(ey));
    endtask

    task automatic send_byte(logic [7:0] b);
        for (int i = 0; i < 8; i++) drive(1, i == 0, b[i], 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        dif.valid_i = 0;
        dif.frame_start = 0;
        dif.din = 0;
        dif.g_n = 0;
        #1;
        chk("rst_sel", 32'(dif.sel), 0);
        chk("rst_y_n", 32'(dif.y_n), 32'hFF);
        chk("rst_dout", 32'(dif.dout), 0);
        chk("rst_fv", 32'(dif.frame_valid), 0);
        chk("rst_se", 32'(dif.sync_err), 0);
        chk("rst_cnt", 32'(dif.frame_cnt), 0);
        in_frame = 0;
        bits.delete();
        m_cnt = 8'd0;
        exp_q.delete();
        exp_sync = 0;
        sync_seen = 0;
        fv_cyc.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic settle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("pending_frames", 32'(exp_q.size()), 0);
        chk("pending_sync", 32'(exp_sync), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (dif.frame_valid) begin
                fv_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL frame_valid: got unexpected pulse dout=%0h expected none", dif.dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_dout", 32'(dif.dout), 32'(e.d));
                    chk("sb_frame_cnt", 32'(dif.frame_cnt), 32'(e.c));
                end
            end
            if (dif.sync_err) begin
                sync_seen++;
                n_chk++;
                if (exp_sync == 0) begin
                    n_fail++;
                    $display("FAIL sync_err: got unexpected pulse expected none");
                end else exp_sync--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // Directed 1
        send_byte(8'h4D);
        settle();
        chk("t1_dout", 32'(dif.dout), 32'h4D);
        chk("t1_cnt", 32'(dif.frame_cnt), 1);
        chk("t1_pulses", 32'(fv_cyc.size()), 1);
        // Directed 2
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, i == 0, 1'($urandom), 0);
        send_byte(8'hFF);
        settle();
        chk("t2_sync", 32'(sync_seen), 1);
        chk("t2_dout", 32'(dif.dout), 32'hFF);
        chk("t2_cnt", 32'(dif.frame_cnt), 1);
        // Directed 3
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, i == 0, 1'(8'h3C >> i), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1'($urandom), 1);
            chk("t3_fv_gated", 32'(dif.frame_valid), 0);
        end
        for (int i = 4; i < 8; i++) drive(1, 0, 1'(8'h3C >> i), 0);
        settle();
        chk("t3_dout", 32'(dif.dout), 32'h3C);
        chk("t3_cnt", 32'(dif.frame_cnt), 1);
        // Directed 4
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h5A);
        settle();
        chk("t4_pulses", 32'(fv_cyc.size()), 2);
        if (fv_cyc.size() == 2) chk("t4_spacing", 32'(fv_cyc[1] - fv_cyc[0]), 8);
        chk("t4_dout", 32'(dif.dout), 32'h5A);
        chk("t4_cnt", 32'(dif.frame_cnt), 2);
        // Directed 5
        do_reset();
        send_byte(8'h77);
        for (int i = 0; i < 5; i++) drive(1, i == 0, 1'($urandom), 0);
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, 0, 1'($urandom), 0);
        settle();
        chk("t5_dout", 32'(dif.dout), 0);
        chk("t5_cnt", 32'(dif.frame_cnt), 0);
        chk("t5_pulses", 32'(fv_cyc.size()), 0);
        // Directed 6: 256 frames with random gaps
        do_reset();
        for (int f = 0; f < 256; f++) begin
            send_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) drive(0, 1'($urandom), 1'($urandom), 0);
        end
        settle();
        chk("t6_cnt_wrap", 32'(dif.frame_cnt), 0);
        chk("t6_pulses", 32'(fv_cyc.size()), 256);
        // Random mix of strobes, frame_start, gaps and g_n holds
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  1'($urandom), $urandom_range(0, 9) == 0);
        end
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: SLOT_W, default 3, slot-index width; N_SLOTS = 2**SLOT_W; only 3 is supported.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: g_n  input  1  active-low enable; when high, the block ignores all inputs.
REQ-006 Port: valid_i  input  1  slot strobe: din carries one slot bit this cycle.
REQ-007 Port: frame_start  input  1  marks the din bit as slot 0; qualified by valid_i.
REQ-008 Port: din  input  1  serial TDM data bit from the mux side.
REQ-009 Port: sel  output  SLOT_W  index of the next expected slot.
REQ-010 Port: y_n  output  N_SLOTS  active-low one-hot decode of sel; all ones when IDLE or g_n=1.
REQ-011 Port: dout  output  N_SLOTS  last complete frame; bit i = slot i.
REQ-012 Port: frame_valid  output  1  one-cycle pulse when dout updates.
REQ-013 Port: sync_err  output  1  one-cycle pulse when frame_start aborts a partial frame.
REQ-014 Port: frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-015 FSM states SHALL be IDLE and RECV; an accepted strobe SHALL be valid_i=1 and g_n=0 at a rising edge.
REQ-016 IDLE: an accepted strobe with frame_start=0 SHALL be discarded with no state change.
REQ-017 IDLE, accepted strobe with frame_start=1: shift[0]<=din, sel<=1, state<=RECV.
REQ-018 RECV, accepted strobe with frame_start=0 and sel<7: shift[sel]<=din, sel<=sel+1.
REQ-019 RECV, accepted strobe with frame_start=0 and sel=7: dout<={din,shift[6:0]}, frame_valid<=1, frame_cnt<=frame_cnt+1, sel<=0, state<=IDLE, all on the same edge.
REQ-020 RECV, accepted strobe with frame_start=1: sync_err<=1, shift<=0, shift[0]<=din, sel<=1, and state SHALL stay RECV; dout SHALL be unchanged.
REQ-021 frame_start without valid_i SHALL be ignored in all states.
REQ-022 When g_n=1, all registers SHALL hold their values, and frame_valid and sync_err SHALL be 0 on the next cycle.
REQ-023 frame_valid and sync_err SHALL be registered and high for exactly one cycle per event.
REQ-024 Back-to-back frames SHALL be supported: a frame_start strobe on the cycle after slot 7 SHALL start a new frame with no lost bits.
REQ-025 y_n SHALL be the combinational LS138-style decode of sel, gated by (state==RECV && g_n==0).

Reset
REQ-026 rst_n=0 SHALL set the following immediately and asynchronously: state=IDLE, sel=0, shift=0, dout=0, frame_valid=0, sync_err=0, frame_cnt=0, and therefore y_n=8'hFF.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after reset release, the block SHALL wait for frame_start.

Structure
REQ-028 The package lab2_pkg SHALL hold the state enum (IDLE, RECV), SLOT_W, and N_SLOTS.
REQ-029 The 3-to-8 active-low decoder SHALL be a separate sub-module ls138, with inputs a, b, c, enable and output y_n[7:0].

Verification
REQ-030 Directed test 1: strobe frame 1,0,1,1,0,0,1,0 for slots 0..7 with frame_start on slot 0. Required: dout=8'h4D, one frame_valid pulse, frame_cnt=1.
REQ-031 Directed test 2: send slots 0..3, then frame_start on the next strobe, then a full frame of 8'hFF. Required: one sync_err pulse, dout=8'hFF, frame_cnt=1.
REQ-032 Directed test 3: hold g_n=1 during slot 4 strobes, then resume. Required: sel holds at 4, y_n=8'hFF while g_n=1, and the frame completes correctly after release.
REQ-033 Directed test 4: send two back-to-back frames, 8'hA5 then 8'h5A, with no idle cycle. Required: two frame_valid pulses 8 strobes apart and frame_cnt=2.
REQ-034 Directed test 5: assert rst_n low at slot 5 mid-frame, then apply strobes without frame_start. Required: outputs at reset values, no frame_valid pulse.
REQ-035 Directed test 6: run 256 complete frames. Required: frame_cnt wraps to 0; y_n equals ~(8'h01<<sel) on every RECV cycle.
